wb_arbiter: RTL and testbench

- Merges the in-order pipeline writeback with out-of-order long-latency results (divider, load miss unit) onto the single register-file write port (rd_addr_wb / rd_data_wb / rd_en_wb).
- Buffers long-latency responses in a small FIFO.
- Keeps a per-register busy scoreboard that the issue stage reads to stall dependent or WAW instructions.

---
 rtl/wb_pkg.sv | 17 +
 rtl/wb_fifo.sv | 73 +++++++
 rtl/wb_arbiter.sv | 150 +++++++++++++++
 tb/tb_wb_arbiter.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_pkg.sv
// wb_pkg: shared types and constants for the writeback arbiter.
//   wb_entry_t - one buffered long-latency response (destination + data).
//   DATA_W     - data width carried by wb_entry_t (register-file width).
//   REG_ADDR_W - register address width.
//   NUM_REGS   - architectural register count (x0 is hardwired zero).
package wb_pkg;

  localparam int DATA_W     = 32;
  localparam int REG_ADDR_W = 5;
  localparam int NUM_REGS   = 32;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd;
    logic [DATA_W-1:0]     data;
  } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// wb_fifo: synchronous FIFO of wb_entry_t, no bypass.
//   clk, rst   - clock, synchronous active-high reset (empties the FIFO).
//   push       - write push_data this cycle (ignored when full).
//   push_data  - entry to write.
//   pop        - drop the head entry this cycle (ignored when empty).
//   full       - occupancy equals DEPTH.
//   empty      - occupancy is zero.
//   head       - oldest entry; valid only while !empty.
module wb_fifo
  import wb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      push,
  input  wb_entry_t push_data,
  input  logic      pop,
  output logic      full,
  output logic      empty,
  output wb_entry_t head
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  wb_entry_t        mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  assign full    = (count_q == CNT_W'(DEPTH));
  assign empty   = (count_q == '0);
  assign head    = mem_q[rd_ptr_q];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: the storage array has no reset; entries are only observed after
  // being written, and leaving it unreset lets it map onto plain RAM.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/wb_arbiter.sv
// wb_arbiter: merges in-order pipeline writeback with buffered long-latency
// responses onto the single register-file write port, and keeps the
// per-register busy scoreboard used by issue.
//   clk, rst          - clock, synchronous active-high reset.
//   pipe_*_wb         - in-order result (valid/rd/data); never back-pressured.
//   ll_alloc_valid/rd - long-latency op issued; marks rd busy.
//   ll_resp_*         - long-latency response (valid/ready/rd/data).
//   busy              - scoreboard, bit 0 always 0.
//   wb_stall          - registered; upstream must keep pipe_valid_wb low.
//   rd_addr/data/en_wb- registered register-file write port.
//   protocol_err      - sticky protocol violation flag.
module wb_arbiter
  import wb_pkg::*;
#(
  parameter int DW         = 32,
  parameter int LQ_DEPTH   = 4,
  parameter int STARVE_MAX = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  pipe_valid_wb,
  input  logic [REG_ADDR_W-1:0] pipe_rd_addr_wb,
  input  logic [DW-1:0]         pipe_rd_data_wb,
  input  logic                  ll_alloc_valid,
  input  logic [REG_ADDR_W-1:0] ll_alloc_rd,
  input  logic                  ll_resp_valid,
  output logic                  ll_resp_ready,
  input  logic [REG_ADDR_W-1:0] ll_resp_rd,
  input  logic [DW-1:0]         ll_resp_data,
  output logic [NUM_REGS-1:0]   busy,
  output logic                  wb_stall,
  output logic [REG_ADDR_W-1:0] rd_addr_wb,
  output logic [DW-1:0]         rd_data_wb,
  output logic                  rd_en_wb,
  output logic                  protocol_err
);

  localparam int STARVE_W = $clog2(STARVE_MAX + 1);

  wb_entry_t fifo_in, fifo_head;
  logic      fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic      pipe_take;

  logic [REG_ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic [DW-1:0]         rd_data_q, rd_data_d;
  logic                  rd_en_q, rd_en_d;
  logic [NUM_REGS-1:0]   busy_q, busy_d;
  logic                  wb_stall_q, wb_stall_d;
  logic                  protocol_err_q, protocol_err_d;
  logic [STARVE_W-1:0]   starve_q, starve_d, starve_inc;

  assign fifo_in.rd   = ll_resp_rd;
  assign fifo_in.data = ll_resp_data;

  wb_fifo #(.DEPTH(LQ_DEPTH)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (fifo_push),
    .push_data (fifo_in),
    .pop       (fifo_pop),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .head      (fifo_head)
  );

  // A pipeline write to x0 does not occupy the port, so the FIFO may pop.
  assign pipe_take     = pipe_valid_wb && (pipe_rd_addr_wb != '0);
  assign fifo_pop      = !pipe_take && !fifo_empty;
  assign fifo_push     = ll_resp_valid && !fifo_full;
  assign ll_resp_ready = !fifo_full;

  // Write-port selection.
  always_comb begin
    rd_en_d   = 1'b0;
    rd_addr_d = rd_addr_q;
    rd_data_d = rd_data_q;
    if (pipe_take) begin
      rd_en_d   = 1'b1;
      rd_addr_d = pipe_rd_addr_wb;
      rd_data_d = pipe_rd_data_wb;
    end else if (fifo_pop && (fifo_head.rd != '0)) begin
      rd_en_d   = 1'b1;
      rd_addr_d = fifo_head.rd;
      rd_data_d = fifo_head.data;
    end
  end

  // Scoreboard: clear on pop first so a same-cycle set overrides it.
  always_comb begin
    busy_d = busy_q;
    if (fifo_pop && (fifo_head.rd != '0)) busy_d[fifo_head.rd] = 1'b0;
    if (ll_alloc_valid && (ll_alloc_rd != '0)) busy_d[ll_alloc_rd] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_comb begin
    protocol_err_d = protocol_err_q;
    if (ll_alloc_valid && (ll_alloc_rd != '0) && busy_q[ll_alloc_rd])
      protocol_err_d = 1'b1;
    if (pipe_valid_wb && (pipe_rd_addr_wb != '0) && busy_q[pipe_rd_addr_wb])
      protocol_err_d = 1'b1;
    if (ll_resp_valid && (ll_resp_rd != '0) && !busy_q[ll_resp_rd])
      protocol_err_d = 1'b1;
    if (pipe_valid_wb && wb_stall_q)
      protocol_err_d = 1'b1;
  end

  // Starvation: count cycles the pipeline holds off a waiting FIFO entry;
  // on the STARVE_MAX-th such cycle, request one stall cycle.
  always_comb begin
    starve_inc = starve_q + 1'b1;
    starve_d   = '0;
    wb_stall_d = 1'b0;
    if (!fifo_empty && pipe_take) begin
      if (starve_inc == STARVE_W'(STARVE_MAX)) begin
        wb_stall_d = 1'b1;
      end else begin
        starve_d = starve_inc;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_addr_q      <= '0;
      rd_data_q      <= '0;
      rd_en_q        <= 1'b0;
      busy_q         <= '0;
      wb_stall_q     <= 1'b0;
      protocol_err_q <= 1'b0;
      starve_q       <= '0;
    end else begin
      rd_addr_q      <= rd_addr_d;
      rd_data_q      <= rd_data_d;
      rd_en_q        <= rd_en_d;
      busy_q         <= busy_d;
      wb_stall_q     <= wb_stall_d;
      protocol_err_q <= protocol_err_d;
      starve_q       <= starve_d;
    end
  end

  assign rd_addr_wb   = rd_addr_q;
  assign rd_data_wb   = rd_data_q;
  assign rd_en_wb     = rd_en_q;
  assign busy         = busy_q;
  assign wb_stall     = wb_stall_q;
  assign protocol_err = protocol_err_q;

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed testbench for wb_arbiter. Inputs change 1 time unit after each
// rising edge; registered outputs are sampled at that same point, so a value
// checked after tick() reflects the inputs of the previous cycle.
module tb_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        pipe_valid_wb;
  logic [4:0]  pipe_rd_addr_wb;
  logic [31:0] pipe_rd_data_wb;
  logic        ll_alloc_valid;
  logic [4:0]  ll_alloc_rd;
  logic        ll_resp_valid;
  logic        ll_resp_ready;
  logic [4:0]  ll_resp_rd;
  logic [31:0] ll_resp_data;
  logic [31:0] busy;
  logic        wb_stall;
  logic [4:0]  rd_addr_wb;
  logic [31:0] rd_data_wb;
  logic        rd_en_wb;
  logic        protocol_err;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  wb_arbiter #(.DW(32), .LQ_DEPTH(4), .STARVE_MAX(8)) dut (
    .clk             (clk),
    .rst             (rst),
    .pipe_valid_wb   (pipe_valid_wb),
    .pipe_rd_addr_wb (pipe_rd_addr_wb),
    .pipe_rd_data_wb (pipe_rd_data_wb),
    .ll_alloc_valid  (ll_alloc_valid),
    .ll_alloc_rd     (ll_alloc_rd),
    .ll_resp_valid   (ll_resp_valid),
    .ll_resp_ready   (ll_resp_ready),
    .ll_resp_rd      (ll_resp_rd),
    .ll_resp_data    (ll_resp_data),
    .busy            (busy),
    .wb_stall        (wb_stall),
    .rd_addr_wb      (rd_addr_wb),
    .rd_data_wb      (rd_data_wb),
    .rd_en_wb        (rd_en_wb),
    .protocol_err    (protocol_err)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    pipe_valid_wb   = 1'b0;
    pipe_rd_addr_wb = '0;
    pipe_rd_data_wb = '0;
    ll_alloc_valid  = 1'b0;
    ll_alloc_rd     = '0;
    ll_resp_valid   = 1'b0;
    ll_resp_rd      = '0;
    ll_resp_data    = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle_inputs();
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (rd_en_wb !== 1'b0) begin failures++; $display("FAIL reset_rd_en got=%b exp=0", rd_en_wb); end
    checks++; if (rd_addr_wb !== 5'd0) begin failures++; $display("FAIL reset_rd_addr got=%0d exp=0", rd_addr_wb); end
    checks++; if (rd_data_wb !== 32'd0) begin failures++; $display("FAIL reset_rd_data got=%h exp=0", rd_data_wb); end
    checks++; if (busy !== 32'd0) begin failures++; $display("FAIL reset_busy got=%h exp=0", busy); end
    checks++; if (wb_stall !== 1'b0) begin failures++; $display("FAIL reset_stall got=%b exp=0", wb_stall); end
    checks++; if (protocol_err !== 1'b0) begin failures++; $display("FAIL reset_err got=%b exp=0", protocol_err); end
    checks++; if (ll_resp_ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b exp=1", ll_resp_ready); end
  endtask

  task automatic test_pipeline();
    do_reset();
    pipe_valid_wb = 1'b1; pipe_rd_addr_wb = 5'd5; pipe_rd_data_wb = 32'hDEADBEEF;
    tick();
    pipe_valid_wb = 1'b0;
    checks++; if (rd_en_wb !== 1'b1) begin failures++; $display("FAIL pipe_en got=%b exp=1", rd_en_wb); end
    checks++; if (rd_addr_wb !== 5'd5) begin failures++; $display("FAIL pipe_addr got=%0d exp=5", rd_addr_wb); end
    checks++; if (rd_data_wb !== 32'hDEADBEEF) begin failures++; $display("FAIL pipe_data got=%h exp=deadbeef", rd_data_wb); end
    checks++; if (protocol_err !== 1'b0) begin failures++; $display("FAIL pipe_err got=%b exp=0", protocol_err); end
    tick();
    checks++; if (rd_en_wb !== 1'b0) begin failures++; $display("FAIL pipe_idle_en got=%b exp=0", rd_en_wb); end
    checks++; if (rd_addr_wb !== 5'd5 || rd_data_wb !== 32'hDEADBEEF) begin failures++; $display("FAIL pipe_hold got=%0d/%h exp=5/deadbeef", rd_addr_wb, rd_data_wb); end
  endtask

  task automatic test_long_latency();
    do_reset();
    ll_alloc_valid = 1'b1; ll_alloc_rd = 5'd7;           // cycle 0
    tick();
    ll_alloc_valid = 1'b0;                               // cycle 1
    checks++; if (busy !== 32'h0000_0080) begin failures++; $display("FAIL ll_busy_set got=%h exp=00000080", busy); end
    tick();                                              // cycle 2
    tick();                                              // cycle 3
    ll_resp_valid = 1'b1; ll_resp_rd = 5'd7; ll_resp_data = 32'h1234;
    checks++; if (ll_resp_ready !== 1'b1) begin failures++; $display("FAIL ll_ready got=%b exp=1", ll_resp_ready); end
    tick();                                              // cycle 4
    ll_resp_valid = 1'b0;
    checks++; if (rd_en_wb !== 1'b0) begin failures++; $display("FAIL ll_no_bypass got=%b exp=0", rd_en_wb); end
    checks++; if (busy !== 32'h0000_0080) begin failures++; $display("FAIL ll_busy_hold got=%h exp=00000080", busy); end
    tick();                                              // cycle 5
    checks++; if (rd_en_wb !== 1'b1 || rd_addr_wb !== 5'd7 || rd_data_wb !== 32'h1234) begin failures++; $display("FAIL ll_write got=%b/%0d/%h exp=1/7/00001234", rd_en_wb, rd_addr_wb, rd_data_wb); end
    checks++; if (busy !== 32'd0) begin failures++; $display("FAIL ll_busy_clr got=%h exp=0", busy); end
    checks++; if (protocol_err !== 1'b0) begin failures++; $display("FAIL ll_err got=%b exp=0", protocol_err); end
  endtask

  task automatic test_full_fifo();
    logic [4:0] exp_rd [5];
    exp_rd[0] = 5'd1; exp_rd[1] = 5'd2; exp_rd[2] = 5'd3; exp_rd[3] = 5'd4; exp_rd[4] = 5'd11;
    do_reset();
    pipe_valid_wb = 1'b1; pipe_rd_addr_wb = 5'd10; pipe_rd_data_wb = 32'hA0A0;
    for (int i = 1; i <= 4; i++) begin                   // cycles 0..3
      ll_alloc_valid = 1'b1; ll_alloc_rd = 5'(i);
      tick();
    end
    for (int i = 1; i <= 4; i++) begin                   // cycles 4..7
      ll_alloc_valid = (i == 1); ll_alloc_rd = 5'd11;
      ll_resp_valid = 1'b1; ll_resp_rd = 5'(i); ll_resp_data = 32'h100 + 32'(i);
      checks++; if (ll_resp_ready !== 1'b1) begin failures++; $display("FAIL full_ready_push%0d got=%b exp=1", i, ll_resp_ready); end
      tick();
    end
    ll_alloc_valid = 1'b0;                               // cycle 8
    ll_resp_rd = 5'd11; ll_resp_data = 32'h10B;
    checks++; if (ll_resp_ready !== 1'b0) begin failures++; $display("FAIL full_ready_c8 got=%b exp=0", ll_resp_ready); end
    tick();                                              // cycle 9
    checks++; if (ll_resp_ready !== 1'b0) begin failures++; $display("FAIL full_ready_c9 got=%b exp=0", ll_resp_ready); end
    checks++; if (rd_en_wb !== 1'b1 || rd_addr_wb !== 5'd10 || rd_data_wb !== 32'hA0A0) begin failures++; $display("FAIL full_pipe_wins got=%b/%0d/%h exp=1/10/0000a0a0", rd_en_wb, rd_addr_wb, rd_data_wb); end
    tick();                                              // cycle 10
    pipe_valid_wb = 1'b0;
    checks++; if (ll_resp_ready !== 1'b0) begin failures++; $display("FAIL full_ready_c10 got=%b exp=0", ll_resp_ready); end
    for (int k = 0; k < 5; k++) begin                    // cycles 11..15
      tick();
      if (k == 0) begin
        checks++; if (ll_resp_ready !== 1'b1) begin failures++; $display("FAIL full_ready_after_pop got=%b exp=1", ll_resp_ready); end
      end
      if (k == 1) ll_resp_valid = 1'b0;
      checks++;
      if (rd_en_wb !== 1'b1 || rd_addr_wb !== exp_rd[k] || rd_data_wb !== (32'h100 + 32'(exp_rd[k]))) begin
        failures++;
        $display("FAIL full_order%0d got=%b/%0d/%h exp=1/%0d/%h", k, rd_en_wb, rd_addr_wb, rd_data_wb, exp_rd[k], 32'h100 + 32'(exp_rd[k]));
      end
    end
    tick();                                              // cycle 16
    checks++; if (rd_en_wb !== 1'b0) begin failures++; $display("FAIL full_drained got=%b exp=0", rd_en_wb); end
    checks++; if (busy !== 32'd0 || protocol_err !== 1'b0) begin failures++; $display("FAIL full_final got=%h/%b exp=0/0", busy, protocol_err); end
  endtask

  task automatic test_starvation();
    do_reset();
    pipe_valid_wb = 1'b1; pipe_rd_addr_wb = 5'd12; pipe_rd_data_wb = 32'hC0C0;
    ll_alloc_valid = 1'b1; ll_alloc_rd = 5'd3;           // cycle 0
    tick();
    ll_alloc_valid = 1'b0;                               // cycle 1
    ll_resp_valid = 1'b1; ll_resp_rd = 5'd3; ll_resp_data = 32'h3333;
    tick();
    ll_resp_valid = 1'b0;
    for (int k = 0; k < 8; k++) begin                    // cycles 2..9: blocked
      checks++; if (wb_stall !== 1'b0) begin failures++; $display("FAIL starve_early%0d got=%b exp=0", k, wb_stall); end
      tick();
    end
    checks++; if (wb_stall !== 1'b1) begin failures++; $display("FAIL starve_stall got=%b exp=1", wb_stall); end
    pipe_valid_wb = 1'b0;                                // cycle 10: upstream obeys
    tick();                                              // cycle 11
    checks++; if (wb_stall !== 1'b0) begin failures++; $display("FAIL starve_one_cycle got=%b exp=0", wb_stall); end
    checks++; if (rd_en_wb !== 1'b1 || rd_addr_wb !== 5'd3 || rd_data_wb !== 32'h3333) begin failures++; $display("FAIL starve_drain got=%b/%0d/%h exp=1/3/00003333", rd_en_wb, rd_addr_wb, rd_data_wb); end
    checks++; if (busy !== 32'd0 || protocol_err !== 1'b0) begin failures++; $display("FAIL starve_final got=%h/%b exp=0/0", busy, protocol_err); end
    tick();                                              // cycle 12: FIFO empty
    checks++; if (wb_stall !== 1'b0) begin failures++; $display("FAIL starve_empty got=%b exp=0", wb_stall); end
  endtask

  task automatic test_hazards();
    do_reset();
    ll_alloc_valid = 1'b1; ll_alloc_rd = 5'd9;           // cycles 0 and 1
    tick();
    checks++; if (protocol_err !== 1'b0) begin failures++; $display("FAIL haz_first_alloc got=%b exp=0", protocol_err); end
    tick();
    ll_alloc_valid = 1'b0;
    checks++; if (protocol_err !== 1'b1) begin failures++; $display("FAIL haz_double_alloc got=%b exp=1", protocol_err); end
    tick();
    checks++; if (protocol_err !== 1'b1) begin failures++; $display("FAIL haz_sticky got=%b exp=1", protocol_err); end

    do_reset();
    checks++; if (protocol_err !== 1'b0) begin failures++; $display("FAIL haz_reset_clears got=%b exp=0", protocol_err); end
    ll_alloc_valid = 1'b1; ll_alloc_rd = 5'd9;           // cycle 0
    tick();
    ll_alloc_valid = 1'b0;                               // cycle 1
    ll_resp_valid = 1'b1; ll_resp_rd = 5'd9; ll_resp_data = 32'h99;
    tick();
    ll_resp_valid = 1'b0;                                // cycle 2: pop + alloc x9
    ll_alloc_valid = 1'b1; ll_alloc_rd = 5'd9;
    tick();
    ll_alloc_valid = 1'b0;                               // cycle 3
    checks++; if (busy !== 32'h0000_0200) begin failures++; $display("FAIL haz_set_wins got=%h exp=00000200", busy); end
    checks++; if (rd_en_wb !== 1'b1 || rd_addr_wb !== 5'd9 || rd_data_wb !== 32'h99) begin failures++; $display("FAIL haz_pop_write got=%b/%0d/%h exp=1/9/00000099", rd_en_wb, rd_addr_wb, rd_data_wb); end
  endtask

  task automatic test_rd_zero();
    do_reset();
    pipe_valid_wb = 1'b1; pipe_rd_addr_wb = 5'd0; pipe_rd_data_wb = 32'hBAD0;
    ll_resp_valid = 1'b1; ll_resp_rd = 5'd0; ll_resp_data = 32'h55;   // cycle 0
    tick();
    ll_resp_valid = 1'b0;                                // cycle 1: x0 pipe, FIFO pops
    checks++; if (rd_en_wb !== 1'b0) begin failures++; $display("FAIL zero_pipe_en got=%b exp=0", rd_en_wb); end
    tick();                                              // cycle 2
    pipe_valid_wb = 1'b0;
    checks++; if (rd_en_wb !== 1'b0 || rd_data_wb !== 32'd0) begin failures++; $display("FAIL zero_resp got=%b/%h exp=0/00000000", rd_en_wb, rd_data_wb); end
    checks++; if (ll_resp_ready !== 1'b1 || protocol_err !== 1'b0) begin failures++; $display("FAIL zero_state got=%b/%b exp=1/0", ll_resp_ready, protocol_err); end
  endtask

  task automatic test_reset_midflight();
    do_reset();
    pipe_valid_wb = 1'b1; pipe_rd_addr_wb = 5'd10; pipe_rd_data_wb = 32'hE0E0;
    for (int i = 1; i <= 3; i++) begin                   // cycles 0..2
      ll_alloc_valid = 1'b1; ll_alloc_rd = 5'(i);
      tick();
    end
    ll_alloc_valid = 1'b0;
    for (int i = 1; i <= 3; i++) begin                   // cycles 3..5
      ll_resp_valid = 1'b1; ll_resp_rd = 5'(i); ll_resp_data = 32'h200 + 32'(i);
      tick();
    end
    checks++; if (busy !== 32'h0000_000E) begin failures++; $display("FAIL mid_busy_before got=%h exp=0000000e", busy); end
    rst = 1'b1;                                          // cycle 6
    idle_inputs();
    tick();
    rst = 1'b0;
    checks++; if (busy !== 32'd0 || ll_resp_ready !== 1'b1 || rd_en_wb !== 1'b0) begin failures++; $display("FAIL mid_reset got=%h/%b/%b exp=0/1/0", busy, ll_resp_ready, rd_en_wb); end
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++; if (rd_en_wb !== 1'b0) begin failures++; $display("FAIL mid_no_write%0d got=%b exp=0", k, rd_en_wb); end
    end
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    test_reset();
    test_pipeline();
    test_long_latency();
    test_full_fifo();
    test_starvation();
    test_hazards();
    test_rd_zero();
    test_reset_midflight();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
